aes_mode_ctrl: RTL and testbench

- Multi-block sequencer for the 128-bit AES encryption core (aes_cipher_top ld/done/key/text_in/text_out interface).
- Accepts a job (mode, key, IV, block count) from the register block, then streams 128-bit blocks through the core in ECB, CBC-encrypt or CTR mode.
- Applies chaining/counter XORs around the core and returns results on a valid/ready stream.
- Sits between the register/DMA front end and u_cipher.

---
 rtl/aes_mode_ctrl_pkg.sv | 21 ++
 rtl/aes_mode_ctrl_if.sv | 26 ++
 rtl/aes_mode_ctrl_xform.sv | 34 +++
 rtl/aes_mode_ctrl.sv | 151 +++++++++++++++
 tb/tb_aes_mode_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_mode_ctrl_pkg.sv
// Shared types for the AES multi-block mode sequencer.
package aes_ctrl_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    AES_ECB = 2'b00,
    AES_CBC = 2'b01,
    AES_CTR = 2'b10
  } aes_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_LOAD,
    ST_BUSY,
    ST_OUTPUT,
    ST_DRAIN
  } aes_state_e;

endpackage

// File: rtl/aes_mode_ctrl_if.sv
// Block stream plus cipher-core handshake seen by the mode sequencer.
interface aes_mode_ctrl_if;
  import aes_ctrl_pkg::*;

  logic                 blk_in_valid;
  logic [AES_BLK_W-1:0] blk_in_data;
  logic                 blk_in_ready;
  logic                 blk_out_valid;
  logic [AES_BLK_W-1:0] blk_out_data;
  logic                 blk_out_ready;
  logic                 aes_ld;
  logic [AES_BLK_W-1:0] aes_key;
  logic [AES_BLK_W-1:0] aes_text_in;
  logic                 aes_done;
  logic [AES_BLK_W-1:0] aes_text_out;

  modport master (
    input  blk_in_valid, blk_in_data, blk_out_ready, aes_done, aes_text_out,
    output blk_in_ready, blk_out_valid, blk_out_data, aes_ld, aes_key, aes_text_in
  );

  modport slave (
    output blk_in_valid, blk_in_data, blk_out_ready, aes_done, aes_text_out,
    input  blk_in_ready, blk_out_valid, blk_out_data, aes_ld, aes_key, aes_text_in
  );
endinterface

// File: rtl/aes_mode_ctrl_xform.sv
// Combinational chaining/counter transforms applied around the cipher core.
module aes_mode_xform
  import aes_ctrl_pkg::*;
(
  input  aes_mode_e            mode_i,
  input  logic [AES_BLK_W-1:0] blk_i,
  input  logic [AES_BLK_W-1:0] chain_i,
  input  logic [AES_BLK_W-1:0] pt_i,
  input  logic [AES_BLK_W-1:0] core_out_i,
  output logic [AES_BLK_W-1:0] core_in_o,
  output logic [AES_BLK_W-1:0] result_o,
  output logic [AES_BLK_W-1:0] chain_o
);

  always_comb begin
    core_in_o = blk_i;
    result_o  = core_out_i;
    chain_o   = chain_i;
    case (mode_i)
      AES_CBC: begin
        core_in_o = blk_i ^ chain_i;
        chain_o   = core_out_i;
      end
      AES_CTR: begin
        // chain_i holds the counter; only the low word increments and wraps
        core_in_o = chain_i;
        result_o  = core_out_i ^ pt_i;
        chain_o   = {chain_i[AES_BLK_W-1:32], chain_i[31:0] + 32'd1};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_mode_ctrl.sv
// Job sequencer streaming blocks through the AES core in ECB, CBC or CTR mode.
module aes_mode_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [1:0]           cfg_mode,
  input  logic [AES_BLK_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic [CNT_W-1:0]     cfg_num_blk,
  aes_mode_ctrl_if.master      bus,
  output logic                 busy,
  output logic                 job_done,
  output logic                 err_timeout,
  output logic                 err_mode,
  output logic [CNT_W-1:0]     blk_done_cnt
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  aes_state_e           state_q;
  aes_mode_e            mode_q;
  logic [AES_BLK_W-1:0] key_q, text_in_q, out_q, chain_q, pt_q;
  logic [CNT_W-1:0]     remain_q, cnt_q;
  logic [WD_W-1:0]      wdog_q;
  logic                 job_done_q, err_timeout_q, err_mode_q;
  logic [AES_BLK_W-1:0] core_in_d, result_d, chain_d;
  logic                 wd_expire;

  aes_mode_xform u_xform (
    .mode_i     (mode_q),
    .blk_i      (bus.blk_in_data),
    .chain_i    (chain_q),
    .pt_i       (pt_q),
    .core_out_i (bus.aes_text_out),
    .core_in_o  (core_in_d),
    .result_o   (result_d),
    .chain_o    (chain_d)
  );

  // wdog_q counts the LOAD cycle too, so expiry lands TIMEOUT cycles after aes_ld
  assign wd_expire = (32'(wdog_q) + 32'd1) >= TIMEOUT;

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= AES_ECB;
      key_q         <= '0;
      text_in_q     <= '0;
      out_q         <= '0;
      chain_q       <= '0;
      pt_q          <= '0;
      remain_q      <= '0;
      cnt_q         <= '0;
      wdog_q        <= '0;
      job_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_mode_q    <= 1'b0;
    end else begin
      job_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_mode == 2'b11) begin
              err_mode_q <= 1'b1;
            end else begin
              err_mode_q    <= 1'b0;
              err_timeout_q <= 1'b0;
              cnt_q         <= '0;
              mode_q        <= aes_mode_e'(cfg_mode);
              key_q         <= cfg_key;
              chain_q       <= cfg_iv;
              remain_q      <= cfg_num_blk;
              if (cfg_num_blk == '0) job_done_q <= 1'b1;
              else                   state_q    <= ST_WAIT_IN;
            end
          end
        end
        ST_WAIT_IN: begin
          if (cfg_abort) begin
            state_q <= ST_IDLE;
          end else if (bus.blk_in_valid) begin
            text_in_q <= core_in_d;
            pt_q      <= bus.blk_in_data;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wdog_q  <= WD_W'(1);
          state_q <= cfg_abort ? ST_IDLE : ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.aes_done) begin
            out_q   <= result_d;
            chain_q <= chain_d;
            state_q <= cfg_abort ? ST_IDLE : ST_OUTPUT;
          end else if (wd_expire) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
            if (cfg_abort) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.aes_done) begin
            state_q <= ST_IDLE;
          end else if (wd_expire) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (cfg_abort) begin
            state_q <= ST_IDLE;
          end else if (bus.blk_out_ready) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            remain_q <= remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
              job_done_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_IN;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.blk_in_ready  = (state_q == ST_WAIT_IN);
  assign bus.blk_out_valid = (state_q == ST_OUTPUT);
  assign bus.blk_out_data  = out_q;
  assign bus.aes_ld        = (state_q == ST_LOAD);
  assign bus.aes_key       = key_q;
  assign bus.aes_text_in   = text_in_q;
  assign busy              = (state_q != ST_IDLE);
  assign job_done          = job_done_q;
  assign err_timeout       = err_timeout_q;
  assign err_mode          = err_mode_q;
  assign blk_done_cnt      = cnt_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with a behavioural stand-in for the cipher core.
module tb_aes_mode_ctrl;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] K      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int           CORE_LAT = 5;

  logic         mclk = 1'b0;
  logic         rst  = 1'b1;
  logic         cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic [127:0] cfg_key = '0, cfg_iv = '0;
  logic [15:0]  cfg_num_blk = '0;
  logic         busy, job_done, err_timeout, err_mode;
  logic [15:0]  blk_done_cnt;

  int n_checks = 0;
  int n_errors = 0;

  aes_mode_ctrl_if ifc ();

  aes_mode_ctrl #(.CNT_W(16), .TIMEOUT(16)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_mode     (cfg_mode),
    .cfg_key      (cfg_key),
    .cfg_iv       (cfg_iv),
    .cfg_num_blk  (cfg_num_blk),
    .bus          (ifc),
    .busy         (busy),
    .job_done     (job_done),
    .err_timeout  (err_timeout),
    .err_mode     (err_mode),
    .blk_done_cnt (blk_done_cnt)
  );

  always #5 mclk = ~mclk;

  // Stand-in cipher: the FIPS-197 vector for its own key/plaintext, else swap halves ^ key.
  function automatic logic [127:0] mock_e(input logic [127:0] t, input logic [127:0] k);
    if (t == P && k == K) return C_FIPS;
    return {t[63:0], t[127:64]} ^ k;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  bit           core_en = 1'b1;
  bit           pend = 1'b0;
  int           core_cnt = 0;
  logic [127:0] cap_t, cap_k;

  initial begin
    ifc.aes_done     = 1'b0;
    ifc.aes_text_out = '0;
  end

  always @(negedge mclk) begin
    ifc.aes_done = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (core_cnt == 0) begin
          ifc.aes_done     = 1'b1;
          ifc.aes_text_out = mock_e(cap_t, cap_k);
          pend             = 1'b0;
        end else begin
          core_cnt--;
        end
      end
      if (ifc.aes_ld && core_en) begin
        pend     = 1'b1;
        core_cnt = CORE_LAT;
        cap_t    = ifc.aes_text_in;
        cap_k    = ifc.aes_key;
      end
    end
  end

  task automatic start_job(input logic [1:0] m, input logic [127:0] iv, input logic [15:0] n);
    cfg_mode    = m;
    cfg_key     = K;
    cfg_iv      = iv;
    cfg_num_blk = n;
    cfg_start   = 1'b1;
    @(negedge mclk);
    cfg_start   = 1'b0;
  endtask

  // Returns at the negedge after the handshake, with the LOAD-cycle core input.
  task automatic send_blk(input logic [127:0] p, output logic [127:0] tin);
    int n = 0;
    ifc.blk_in_valid = 1'b1;
    ifc.blk_in_data  = p;
    while (!ifc.blk_in_ready && n < 200) begin
      @(negedge mclk);
      n++;
    end
    if (n >= 200) chk("send_wait", 128'(ifc.blk_in_ready), 128'(1));
    @(negedge mclk);
    ifc.blk_in_valid = 1'b0;
    tin = ifc.aes_text_in;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ifc.blk_out_valid && n < 200) begin
      @(negedge mclk);
      n++;
    end
    if (n >= 200) chk("recv_wait", 128'(ifc.blk_out_valid), 128'(1));
  endtask

  task automatic recv_blk(output logic [127:0] d);
    ifc.blk_out_ready = 1'b1;
    wait_valid();
    d = ifc.blk_out_data;
    @(negedge mclk);
    ifc.blk_out_ready = 1'b0;
  endtask

  logic [127:0] tin, d, first;
  logic [127:0] bp_blk [3];
  logic [127:0] ctr_iv;
  int           bad, n, vseen, jdseen;

  initial begin
    ifc.blk_in_valid  = 1'b0;
    ifc.blk_in_data   = '0;
    ifc.blk_out_ready = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_key", ifc.aes_key, '0);
    chk("rst_tin", ifc.aes_text_in, '0);
    chk("rst_out", ifc.blk_out_data, '0);
    chk("rst_cnt", 128'(blk_done_cnt), 128'(0));
    chk("rst_ready", 128'(ifc.blk_in_ready), 128'(0));
    rst = 1'b0;
    @(negedge mclk);

    // ECB single block, FIPS-197 vector
    start_job(2'b00, '0, 16'd1);
    chk("ecb_busy", 128'(busy), 128'(1));
    send_blk(P, tin);
    chk("ecb_tin", tin, P);
    chk("ecb_key", ifc.aes_key, K);
    recv_blk(d);
    chk("ecb_out", d, C_FIPS);
    chk("ecb_jd", 128'(job_done), 128'(1));
    chk("ecb_cnt", 128'(blk_done_cnt), 128'(1));
    @(negedge mclk);
    chk("ecb_jd_pulse", 128'(job_done), 128'(0));
    chk("ecb_idle", 128'(busy), 128'(0));

    // CBC two blocks, IV 0
    start_job(2'b01, '0, 16'd2);
    send_blk(P, tin);
    chk("cbc_tin0", tin, P);
    recv_blk(d);
    chk("cbc_out0", d, C_FIPS);
    send_blk(P, tin);
    chk("cbc_tin1", tin, 128'h69d5c2eb2e2e624750541d3bbc692ba5);
    recv_blk(d);
    chk("cbc_out1", d, 128'h50551f38b86c2da261dcc8e022236c48);
    chk("cbc_cnt", 128'(blk_done_cnt), 128'(2));

    // CTR two blocks, low counter word wraps
    ctr_iv = {96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'hffffffff};
    start_job(2'b10, ctr_iv, 16'd2);
    send_blk(P, tin);
    chk("ctr_tin0", tin, ctr_iv);
    recv_blk(d);
    chk("ctr_out0", d, P ^ mock_e(ctr_iv, K));
    send_blk(128'hdeadbeef_01234567_89abcdef_cafef00d, tin);
    chk("ctr_tin1", tin, {96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'h00000000});
    recv_blk(d);
    chk("ctr_out1", d, 128'hdeadbeef_01234567_89abcdef_cafef00d
                       ^ mock_e({96'ha5a5a5a5_a5a5a5a5_a5a5a5a5, 32'h0}, K));

    // ECB three blocks with the sink stalled on the first result
    bp_blk[0] = 128'h11111111_22222222_33333333_44444444;
    bp_blk[1] = 128'h55555555_66666666_77777777_88888888;
    bp_blk[2] = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
    start_job(2'b00, '0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      send_blk(bp_blk[i], tin);
      if (i == 0) begin
        wait_valid();
        first = ifc.blk_out_data;
        bad   = 0;
        repeat (20) begin
          @(negedge mclk);
          if (ifc.blk_out_data !== first || ifc.blk_in_ready || !ifc.blk_out_valid) bad++;
        end
        chk("bp_stall", 128'(bad), 128'(0));
      end
      recv_blk(d);
      chk($sformatf("bp_out%0d", i), d, mock_e(bp_blk[i], K));
    end
    chk("bp_cnt", 128'(blk_done_cnt), 128'(3));

    // Reserved mode
    start_job(2'b11, '0, 16'd1);
    chk("mode_err", 128'(err_mode), 128'(1));
    chk("mode_busy", 128'(busy), 128'(0));

    // Core never answers: watchdog
    core_en = 1'b0;
    @(negedge mclk);
    start_job(2'b00, '0, 16'd1);
    send_blk(P, tin);
    chk("to_ld", 128'(ifc.aes_ld), 128'(1));
    repeat (15) @(negedge mclk);
    chk("to_early", {busy, err_timeout}, 128'b10);
    @(negedge mclk);
    chk("to_err", 128'(err_timeout), 128'(1));
    chk("to_busy", 128'(busy), 128'(0));
    chk("to_jd", 128'(job_done), 128'(0));
    core_en = 1'b1;
    @(negedge mclk);

    // Zero-block job: immediate job_done, clears both sticky errors
    start_job(2'b00, '0, 16'd0);
    chk("zero_jd", 128'(job_done), 128'(1));
    chk("zero_errs", {err_timeout, err_mode}, 128'b00);
    chk("zero_busy", 128'(busy), 128'(0));
    bad = 0;
    repeat (4) begin
      @(negedge mclk);
      if (ifc.aes_ld || busy) bad++;
    end
    chk("zero_no_ld", 128'(bad), 128'(0));

    // Abort while the core is busy: drain until its done, discard the result
    start_job(2'b00, '0, 16'd1);
    send_blk(P, tin);
    @(negedge mclk);
    cfg_abort = 1'b1;
    @(negedge mclk);
    cfg_abort = 1'b0;
    chk("abort_drain", 128'(busy), 128'(1));
    n = 0;
    vseen = 0;
    jdseen = 0;
    while (busy && n < 40) begin
      @(negedge mclk);
      n++;
      if (ifc.blk_out_valid) vseen++;
      if (job_done) jdseen++;
    end
    chk("abort_len", 128'(n), 128'(5));
    chk("abort_novalid", 128'(vseen), 128'(0));
    chk("abort_nojd", 128'(jdseen), 128'(0));
    chk("abort_noerr", 128'(err_timeout), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
